casl_key_loader: RTL and testbench
==================================

# casl_key_loader

Sequential key-delivery stage that sits directly upstream of the CAS-Lock-protected c1908 netlist. It fetches the 64-bit locking key byte-by-byte from an on-chip OTP/key-memory port and verifies an XOR checksum byte. Only then does it drive the verified key onto the netlist's `keyinput_*` bus. Until a verified commit, the key bus is held at all-zeros so the locked core never sees a partially loaded or corrupted key.

## Interface
Parameters:
- `KEY_W`, 64, key width in bits; must be a multiple of 8. `NB = KEY_W/8` data bytes.
- `TIMEOUT`, 255, maximum cycles `otp_req` may stay high without `otp_ack` before the load aborts.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  load request; sampled only in IDLE.
- `otp_req`  out  1  read request to key memory.
- `otp_addr`  out  `$clog2(NB+1)`  byte address; 0..NB-1 are key bytes, NB is the checksum byte.
- `otp_ack`  in  1  read acknowledge; `otp_data` is valid on the same cycle.
- `otp_data`  in  8  read data.
- `key_out`  out  `KEY_W`  key bus. Bit i drives `keyinput_i`. Byte k lands in `key_out[8k+7:8k]`.
- `key_valid`  out  1  high while `key_out` holds a verified key.
- `busy`  out  1  high in any state except IDLE.
- `err`  out  1  sticky error flag: checksum mismatch or timeout.

## Operation
- Reset (`rst_n`=0 at an edge) clears all state: state=IDLE, `key_out`=0, `key_valid`=0, `busy`=0, `err`=0, `otp_req`=0, `otp_addr`=0. A reset in the middle of a load aborts it with no partial commit.
- States: IDLE, REQ, GAP, CHK.
- IDLE, when `start`=1:
  - Clear the shadow register, the XOR accumulator, `otp_addr`, the timeout counter, `err`, `key_valid` and `key_out`.
  - Go to REQ.
- While `busy`=1, `start` is ignored.
- REQ:
  - `otp_req`=1; `otp_addr` is stable.
  - On an edge with `otp_ack`=1 and `otp_addr`<NB: write `otp_data` into shadow byte `otp_addr`, XOR it into the accumulator, increment `otp_addr`, go to GAP.
  - On an edge with `otp_ack`=1 and `otp_addr`=NB: capture the checksum byte and go to CHK.
  - Each REQ cycle without ack increments the timeout counter. If the counter reaches `TIMEOUT` without ack: `err`=1, go to IDLE. `key_out` stays 0 and `key_valid` stays 0.
- GAP:
  - `otp_req`=0 for exactly one cycle; timeout counter is cleared.
  - Go to REQ.
- CHK, one cycle:
  - If accumulator == checksum: `key_out`<=shadow, `key_valid`<=1.
  - Otherwise: `err`<=1, and `key_out` and `key_valid` stay 0.
  - Go to IDLE in both cases.
- `otp_ack` while `otp_req`=0 is ignored.
- `otp_addr` never exceeds NB. The counter saturates; it does not wrap.
- `key_out` changes only at reset, on an accepted `start` (cleared to 0), or on a CHK pass (loaded with the shadow). It never shows shadow contents mid-load.

## Timing
- An accepted `start` at edge 0 puts REQ active in the cycle after edge 0.
- With `otp_ack` tied high:
  - Key byte k is captured at edge 2k+1.
  - The checksum byte is captured at edge 2·NB+1 (edge 17 for KEY_W=64).
  - The CHK decision is at edge 2·NB+2 (edge 18). `key_valid` is high from then on and `busy` is low.
- Each cycle of ack delay adds one cycle to the load.
- `otp_req` is a registered output. It falls in the cycle after the ack edge.
- Timeout: `err` rises at the edge where the no-ack count in REQ reaches `TIMEOUT`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset check: hold `rst_n`=0, then release → `key_out`=0, `key_valid`=0, `busy`=0, `err`=0, `otp_req`=0.
- Nominal load, zero-wait OTP:
  - Memory holds bytes EF CD AB 89 67 45 23 01 with checksum 00; pulse `start`.
  - At edge 18: `key_out`=64'h0123456789ABCDEF, `key_valid`=1, `err`=0.
  - `otp_req` is observed low for one cycle between every pair of requests.
- Checksum mismatch: same bytes with checksum 01 → `err`=1 and `key_valid`=0 at edge 18; `key_out` stays 0.
- Timeout: `otp_ack` held low with `TIMEOUT`=8 → `err`=1 exactly 8 REQ cycles after the request is raised; `busy`=0; `key_out`=0.
- Reload and ignored start:
  - After a valid load, pulse `start` again → `key_valid` and `key_out` clear the next cycle.
  - A second `start` while `busy`=1 has no effect.
  - The reload with random ack delays of 0–5 cycles commits the new key correctly.
- Reset mid-load: assert `rst_n`=0 after byte 3 is captured → all outputs return to reset values, and a fresh `start` completes normally.

Source files
------------

// File: rtl/casl_key_loader.sv
// Fetches the locking key byte-by-byte from key memory, verifies an XOR checksum,
// and only then presents the key to the locked netlist; otherwise the key bus stays zero.
module casl_key_loader #(
  parameter int unsigned KEY_W   = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            otp_req,
  output logic [$clog2(KEY_W/8+1)-1:0]    otp_addr,
  input  logic                            otp_ack,
  input  logic [7:0]                      otp_data,
  output logic [KEY_W-1:0]                key_out,
  output logic                            key_valid,
  output logic                            busy,
  output logic                            err
);

  localparam int unsigned NB = KEY_W / 8;
  localparam int unsigned AW = $clog2(NB + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, CHK} state_t;

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  shadow_q, shadow_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        chk_q, chk_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [AW-1:0]     addr_d;
  logic [KEY_W-1:0]  key_d;
  logic              valid_d, err_d, req_d, busy_d;
  logic              last_c, tmo_hit_c;

  assign last_c    = (otp_addr == AW'(NB));
  // The cycle being counted now is the TIMEOUT-th one without an ack.
  assign tmo_hit_c = (tmo_q >= TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (otp_ack)        state_d = last_c ? CHK : GAP;
        else if (tmo_hit_c) state_d = IDLE;
      end
      GAP:     state_d = REQ;
      CHK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    acc_d    = acc_q;
    chk_d    = chk_q;
    tmo_d    = tmo_q;
    addr_d   = otp_addr;
    key_d    = key_out;
    valid_d  = key_valid;
    err_d    = err;
    req_d    = (state_d == REQ);
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = '0;
          acc_d    = '0;
          addr_d   = '0;
          tmo_d    = '0;
          err_d    = 1'b0;
          valid_d  = 1'b0;
          key_d    = '0;
        end
      end
      REQ: begin
        if (otp_ack) begin
          if (last_c) begin
            chk_d = otp_data;
          end else begin
            for (int unsigned k = 0; k < NB; k++) begin
              if (otp_addr == AW'(k)) shadow_d[8*k +: 8] = otp_data;
            end
            acc_d  = acc_q ^ otp_data;
            addr_d = otp_addr + AW'(1);
          end
        end else begin
          if (tmo_q != TW'(TIMEOUT)) tmo_d = tmo_q + TW'(1);
          if (tmo_hit_c) err_d = 1'b1;
        end
      end
      GAP: tmo_d = '0;
      CHK: begin
        if (acc_q == chk_q) begin
          key_d   = shadow_q;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      acc_q     <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      otp_addr  <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
      otp_req   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      acc_q     <= acc_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      otp_addr  <= addr_d;
      key_out   <= key_d;
      key_valid <= valid_d;
      err       <= err_d;
      otp_req   <= req_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_casl_key_loader.sv
// Directed bench for casl_key_loader with a small key-memory model that answers
// requests after a configurable (zero or random 0..5) delay.
module tb_casl_key_loader;

  localparam int unsigned KEY_W   = 64;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned AW      = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             otp_req;
  logic [AW-1:0]    otp_addr;
  logic             otp_ack;
  logic [7:0]       otp_data;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;

  casl_key_loader #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .otp_req(otp_req), .otp_addr(otp_addr), .otp_ack(otp_ack), .otp_data(otp_data),
    .key_out(key_out), .key_valid(key_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:8];
  logic       ack_en    = 1'b1;
  logic       rand_mode = 1'b0;
  int         wcnt      = 0;
  int         cur_delay = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Key-memory model: answers after cur_delay no-ack cycles of each request.
  always @(negedge clk) begin
    if (!otp_req) begin
      otp_ack   = 1'b0;
      wcnt      = 0;
      cur_delay = rand_mode ? int'($urandom_range(5, 0)) : 0;
    end else if (!ack_en) begin
      otp_ack = 1'b0;
    end else if (wcnt >= cur_delay) begin
      otp_ack  = 1'b1;
      otp_data = mem[otp_addr];
    end else begin
      otp_ack = 1'b0;
      wcnt++;
    end
  end

  task automatic load_mem(input logic [63:0] key, input logic [7:0] cks);
    for (int k = 0; k < 8; k++) mem[k] = key[8*k +: 8];
    mem[8] = cks;
  endtask

  // Start is sampled at the following edge (edge 0); returns #1 after it.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [17:0] req_seen, req_exp;
  int          budget;

  initial begin
    rst_n = 1'b0; start = 1'b0; otp_ack = 1'b0; otp_data = 8'h00;
    load_mem(64'h0123456789ABCDEF, 8'h00);
    step(3);
    @(negedge clk) rst_n = 1'b1;
    step(1);
    check_eq("rst_key", key_out, 64'h0);
    check_eq("rst_valid", 64'(key_valid), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_err", 64'(err), 64'h0);
    check_eq("rst_req", 64'(otp_req), 64'h0);
    check_eq("rst_addr", 64'(otp_addr), 64'h0);

    // Nominal zero-wait load, tracking otp_req after edges 0..17
    pulse_start();
    req_seen[0] = otp_req;
    for (int j = 1; j < 18; j++) begin
      step(1);
      req_seen[j] = otp_req;
    end
    for (int j = 0; j < 18; j++) req_exp[j] = (j < 17) && (j % 2 == 0);
    check_eq("nom_req_pattern", 64'(req_seen), 64'(req_exp));
    check_eq("nom_e17_valid", 64'(key_valid), 64'h0);
    check_eq("nom_e17_key", key_out, 64'h0);
    check_eq("nom_e17_busy", 64'(busy), 64'h1);
    step(1);
    check_eq("nom_key", key_out, 64'h0123456789ABCDEF);
    check_eq("nom_valid", 64'(key_valid), 64'h1);
    check_eq("nom_err", 64'(err), 64'h0);
    check_eq("nom_busy", 64'(busy), 64'h0);

    // Reload with bad checksum; a start while busy must be ignored
    load_mem(64'h0123456789ABCDEF, 8'h01);
    pulse_start();
    check_eq("reload_clr_valid", 64'(key_valid), 64'h0);
    check_eq("reload_clr_key", key_out, 64'h0);
    check_eq("reload_busy", 64'(busy), 64'h1);
    step(4);
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    step(12);
    check_eq("bad_busy_e17", 64'(busy), 64'h1);
    step(1);
    check_eq("bad_err", 64'(err), 64'h1);
    check_eq("bad_valid", 64'(key_valid), 64'h0);
    check_eq("bad_key", key_out, 64'h0);
    check_eq("bad_busy", 64'(busy), 64'h0);

    // Timeout: no ack ever
    ack_en = 1'b0;
    pulse_start();
    check_eq("tmo_err_clr", 64'(err), 64'h0);
    step(7);
    check_eq("tmo_e7_err", 64'(err), 64'h0);
    check_eq("tmo_e7_busy", 64'(busy), 64'h1);
    step(1);
    check_eq("tmo_err", 64'(err), 64'h1);
    check_eq("tmo_busy", 64'(busy), 64'h0);
    check_eq("tmo_req", 64'(otp_req), 64'h0);
    check_eq("tmo_key", key_out, 64'h0);
    ack_en = 1'b1;

    // Reload with random ack delays
    rand_mode = 1'b1;
    load_mem(64'h8877665544332211, 8'h88);
    pulse_start();
    check_eq("rnd_err_clr", 64'(err), 64'h0);
    budget = 0;
    while (busy && budget < 200) begin
      step(1);
      budget++;
    end
    check_eq("rnd_done_in_budget", 64'(budget < 200), 64'h1);
    check_eq("rnd_key", key_out, 64'h8877665544332211);
    check_eq("rnd_valid", 64'(key_valid), 64'h1);
    check_eq("rnd_err", 64'(err), 64'h0);
    rand_mode = 1'b0;

    // Reset after byte 3 captured (edge 7)
    load_mem(64'h0123456789ABCDEF, 8'h00);
    pulse_start();
    step(7);
    check_eq("mid_addr", 64'(otp_addr), 64'h4);
    @(negedge clk) rst_n = 1'b0;
    step(1);
    check_eq("mid_rst_key", key_out, 64'h0);
    check_eq("mid_rst_valid", 64'(key_valid), 64'h0);
    check_eq("mid_rst_busy", 64'(busy), 64'h0);
    check_eq("mid_rst_req", 64'(otp_req), 64'h0);
    check_eq("mid_rst_addr", 64'(otp_addr), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    step(18);
    check_eq("fresh_key", key_out, 64'h0123456789ABCDEF);
    check_eq("fresh_valid", 64'(key_valid), 64'h1);
    check_eq("fresh_busy", 64'(busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
